// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                          |
// | Purpose  : ALU op encodings and result-stage state enum.                    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } state_e;

  // Only arithmetic ops can legitimately overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | Module   : sat_counter                                                      |
// | Purpose  : Saturating up-counter with synchronous clear.                    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_result_stage                                                 |
// | Purpose  : Registers ALU results, qualifies overflow, raises traps.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 8,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  state_e           r_state;
  state_e           w_next_state;
  state_e           w_dest;
  logic             w_ready;
  logic             w_xfer;
  logic             w_qovf;
  logic             w_trap_go;
  logic             w_load;
  logic             r_out_valid;
  logic             r_trap_req;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_ovf;
  logic             r_sticky;

  assign w_qovf    = overflow && is_arith(op);
  assign w_trap_go = w_qovf && (TRAP_EN != 1'b0);
  assign w_xfer    = in_valid && in_ready;
  assign w_load    = w_xfer && !w_trap_go;
  assign w_dest    = w_trap_go ? TRAP : HOLD;

  // Gated by rst_n so the stage never advertises readiness while held in reset.
  assign in_ready = rst_n && w_ready;

  always_comb begin
    w_ready      = 1'b0;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_xfer) w_next_state = w_dest;
      end
      HOLD: begin
        w_ready = out_ready;
        if (out_ready) w_next_state = w_xfer ? w_dest : IDLE;
      end
      TRAP: begin
        if (trap_ack) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_trap_req  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= (w_next_state == HOLD);
      r_trap_req  <= (w_next_state == TRAP);
    end
  end

  // A trapping result is never loaded; the output register keeps its old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else if (w_load) begin
      r_out_result <= result;
      r_out_zero   <= (result == '0);
      r_out_ovf    <= w_qovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_xfer && w_qovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_xfer && w_qovf),
    .clr   (1'b0),
    .count (ovf_count)
  );

  assign out_valid  = r_out_valid;
  assign trap_req   = r_trap_req;
  assign out_result = r_out_result;
  assign out_zero   = r_out_zero;
  assign out_ovf    = r_out_ovf;
  assign sticky_ovf = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_result_stage                                              |
// | Purpose  : Directed self-checking bench for alu_result_stage.               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_result_stage;

  logic clk;
  logic rst_n;

  // dut0: defaults (TRAP_EN=1, CNT_W=8)
  logic        a_in_valid, a_in_ready, a_overflow, a_out_valid, a_out_ready;
  logic [2:0]  a_op;
  logic [31:0] a_result, a_out_result;
  logic        a_out_zero, a_out_ovf, a_trap_req, a_trap_ack, a_sticky, a_clr;
  logic [7:0]  a_cnt;

  // dut1: TRAP_EN=0, CNT_W=2
  logic        b_in_valid, b_in_ready, b_overflow, b_out_valid, b_out_ready;
  logic [2:0]  b_op;
  logic [31:0] b_result, b_out_result;
  logic        b_out_zero, b_out_ovf, b_trap_req, b_trap_ack, b_sticky, b_clr;
  logic [1:0]  b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op(a_op), .result(a_result), .overflow(a_overflow), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_result(a_out_result), .out_zero(a_out_zero),
    .out_ovf(a_out_ovf), .trap_req(a_trap_req), .trap_ack(a_trap_ack),
    .sticky_ovf(a_sticky), .clr_sticky(a_clr), .ovf_count(a_cnt)
  );

  alu_result_stage #(.WIDTH(32), .CNT_W(2), .TRAP_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .result(b_result), .overflow(b_overflow), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_result(b_out_result), .out_zero(b_out_zero),
    .out_ovf(b_out_ovf), .trap_req(b_trap_req), .trap_ack(b_trap_ack),
    .sticky_ovf(b_sticky), .clr_sticky(b_clr), .ovf_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [2:0] o, input logic [31:0] r, input logic ov);
    a_in_valid = v;
    a_op       = o;
    a_result   = r;
    a_overflow = ov;
  endtask

  initial begin
    rst_n = 1'b0;
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    a_out_ready = 1'b1; a_trap_ack = 1'b0; a_clr = 1'b0;
    b_in_valid = 1'b0; b_op = 3'b000; b_result = 32'h0; b_overflow = 1'b0;
    b_out_ready = 1'b1; b_trap_ack = 1'b0; b_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready",   a_in_ready,   0);
    check("rst_out_valid",  a_out_valid,  0);
    check("rst_out_result", a_out_result, 0);
    check("rst_trap_req",   a_trap_req,   0);
    check("rst_count",      a_cnt,        0);
    check("rst_sticky",     a_sticky,     0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // ADD 5, no overflow, one-cycle latency
    a_trap_ack = 1'b1;  // ignored outside TRAP
    a_drive(1'b1, 3'b010, 32'h0000_0005, 1'b0);
    tick();
    a_trap_ack = 1'b0;
    check("add_valid",  a_out_valid,  1);
    check("add_result", a_out_result, 32'h5);
    check("add_zero",   a_out_zero,   0);
    check("add_ovf",    a_out_ovf,    0);
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    tick();
    check("add_drain_valid", a_out_valid, 0);

    // SUB zero result, backpressure held 3 cycles
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b110, 32'h0, 1'b0);
    tick();
    check("sub_zero", a_out_zero, 1);
    a_drive(1'b1, 3'b001, 32'h0000_1234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", a_in_ready,   0);
      tick();
      check("stall_valid",    a_out_valid,  1);
      check("stall_result",   a_out_result, 0);
      check("stall_zero",     a_out_zero,   1);
    end
    // Release with a pending input: back-to-back reload
    a_out_ready = 1'b1;
    #1;
    check("b2b_in_ready", a_in_ready, 1);
    tick();
    check("b2b_valid",  a_out_valid,  1);
    check("b2b_result", a_out_result, 32'h1234);
    check("b2b_zero",   a_out_zero,   0);
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    tick();

    // AND with overflow: not qualified
    a_drive(1'b1, 3'b000, 32'h8000_0000, 1'b1);
    tick();
    check("and_ovf_valid", a_out_valid, 1);
    check("and_ovf_trap",  a_trap_req,  0);
    check("and_ovf_flag",  a_out_ovf,   0);
    check("and_ovf_count", a_cnt,       0);
    check("and_ovf_stky",  a_sticky,    0);
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    tick();

    // ADD overflow traps
    a_drive(1'b1, 3'b010, 32'h8000_0001, 1'b1);
    tick();
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    check("trap_req",   a_trap_req,  1);
    check("trap_valid", a_out_valid, 0);
    check("trap_count", a_cnt,       1);
    check("trap_stky",  a_sticky,    1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_wait_req",   a_trap_req, 1);
      check("trap_wait_ready", a_in_ready, 0);
    end
    a_trap_ack = 1'b1;
    tick();
    a_trap_ack = 1'b0;
    check("ack_trap_req", a_trap_req, 0);
    check("ack_in_ready", a_in_ready, 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clr_sticky", a_sticky, 0);
    check("clr_count_kept", a_cnt, 1);

    // Async reset mid-TRAP
    a_drive(1'b1, 3'b110, 32'h7FFF_FFFF, 1'b1);
    tick();
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    check("trap2_req", a_trap_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trap_req", a_trap_req, 0);
    check("arst_trap_cnt", a_cnt,      0);
    check("arst_trap_rdy", a_in_ready, 0);
    tick();
    rst_n = 1'b1;

    // Async reset mid-HOLD
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b010, 32'h0000_0009, 1'b0);
    tick();
    a_drive(1'b0, 3'b000, 32'h0, 1'b0);
    check("hold_result", a_out_result, 32'h9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid",  a_out_valid,  0);
    check("arst_hold_result", a_out_result, 0);
    check("arst_hold_rdy",    a_in_ready,   0);
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check("rerelease_rdy", a_in_ready, 1);

    // dut1: TRAP_EN=0, CNT_W=2, five back-to-back SUB overflows
    b_in_valid = 1'b1; b_op = 3'b110; b_result = 32'h0000_DEAD; b_overflow = 1'b1;
    tick();
    check("nt_valid", b_out_valid, 1);
    check("nt_ovf",   b_out_ovf,   1);
    check("nt_trap",  b_trap_req,  0);
    check("nt_cnt1",  b_cnt,       1);
    tick(); tick();
    check("nt_cnt3",  b_cnt,       3);
    tick();
    check("nt_cnt_sat4", b_cnt,    3);
    b_clr = 1'b1;
    tick();
    check("nt_cnt_sat5", b_cnt,    3);
    check("nt_set_wins", b_sticky, 1);
    b_in_valid = 1'b1; b_op = 3'b000; b_result = 32'h0; b_overflow = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_clr = 1'b0;
    check("nt_and_ovf",  b_out_ovf,  0);
    check("nt_and_zero", b_out_zero, 1);
    check("nt_clr",      b_sticky,   0);
    tick();
    check("nt_drain", b_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
